// File: rtl/mmio_timer_bank.sv
// rtl/mmio_timer_bank.sv - bank of memory-mapped up-counting timers with reload and interrupt
// Optional per-channel prescaler is built when TIMER_PRESCALE_EN is defined.
module mmio_timer_bank #(
  parameter int          N_TIMERS = 4,
  parameter int          TW       = 32,
  parameter logic [31:0] BASE     = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  localparam logic [TW-1:0] ONES    = '1;
  localparam logic [31:0]   CH_SPAN = 32'(16 * N_TIMERS);

  logic [TW-1:0]       r_th [N_TIMERS];
  logic [TW-1:0]       r_tl [N_TIMERS];
  logic [N_TIMERS-1:0] r_en;
  logic [N_TIMERS-1:0] r_ie;
  logic [N_TIMERS-1:0] r_os;
  logic [N_TIMERS-1:0] r_pend;
`ifdef TIMER_PRESCALE_EN
  logic [15:0]         r_psc_val [N_TIMERS];
  logic [15:0]         r_psc_cnt [N_TIMERS];
`endif

  logic [31:0]         w_off;
  logic                w_ch_hit;
  logic                w_irq_hit;
  logic [2:0]          w_ch;
  logic [1:0]          w_reg;
  logic [N_TIMERS-1:0] w_tick;

  // Offsets are taken relative to BASE so any BASE alignment decodes correctly.
  assign w_off     = addr - BASE;
  assign w_ch_hit  = (w_off < CH_SPAN) && (w_off[1:0] == 2'b00);
  assign w_irq_hit = (w_off == 32'h80);
  assign w_ch      = w_off[6:4];
  assign w_reg     = w_off[3:2];

`ifdef TIMER_PRESCALE_EN
  always_comb begin
    w_tick = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      w_tick[i] = r_en[i] && (r_psc_cnt[i] == r_psc_val[i]);
    end
  end
`else
  assign w_tick = r_en;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en   <= '0;
      r_ie   <= '0;
      r_os   <= '0;
      r_pend <= '0;
      for (int i = 0; i < N_TIMERS; i++) begin
        r_th[i] <= '0;
        r_tl[i] <= '0;
`ifdef TIMER_PRESCALE_EN
        r_psc_val[i] <= '0;
        r_psc_cnt[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < N_TIMERS; i++) begin
`ifdef TIMER_PRESCALE_EN
        if (r_en[i]) begin
          r_psc_cnt[i] <= w_tick[i] ? 16'd0 : r_psc_cnt[i] + 16'd1;
        end
`endif
        if (wr && w_irq_hit && wdata[i]) begin
          r_pend[i] <= 1'b0;
        end
        // Overflow is assigned after the clear so a same-edge overflow keeps pending set.
        if (w_tick[i]) begin
          if (r_tl[i] == ONES) begin
            r_tl[i]   <= r_th[i];
            r_pend[i] <= 1'b1;
            if (r_os[i]) begin
              r_en[i] <= 1'b0;
            end
          end else begin
            r_tl[i] <= r_tl[i] + TW'(1);
          end
        end
        if (wr && w_ch_hit && (w_ch == 3'(i))) begin
          case (w_reg)
            2'd0: r_th[i] <= wdata[TW-1:0];
            2'd1: r_tl[i] <= wdata[TW-1:0];
            2'd2: begin
              r_en[i] <= wdata[0];
              r_ie[i] <= wdata[1];
              r_os[i] <= wdata[2];
`ifdef TIMER_PRESCALE_EN
              r_psc_cnt[i] <= '0;
`endif
            end
            default: begin
`ifdef TIMER_PRESCALE_EN
              r_psc_val[i] <= wdata[15:0];
              r_psc_cnt[i] <= '0;
`endif
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (w_irq_hit) begin
        rdata = 32'(r_pend);
      end
      for (int i = 0; i < N_TIMERS; i++) begin
        if (w_ch_hit && (w_ch == 3'(i))) begin
          case (w_reg)
            2'd0:    rdata = 32'(r_th[i]);
            2'd1:    rdata = 32'(r_tl[i]);
            2'd2:    rdata = {29'd0, r_os[i], r_ie[i], r_en[i]};
`ifdef TIMER_PRESCALE_EN
            default: rdata = 32'(r_psc_val[i]);
`else
            default: rdata = '0;
`endif
          endcase
        end
      end
    end
  end

  assign irqout = |(r_pend & r_ie);

endmodule

// File: tb/tb_mmio_timer_bank.sv
// tb/tb_mmio_timer_bank.sv - directed table, corner sequences and randomized model check for mmio_timer_bank
module tb_mmio_timer_bank;

  localparam logic [31:0] BASE = 32'h40000000;
  localparam logic [31:0] IRQA = BASE + 32'h80;
`ifdef TIMER_PRESCALE_EN
  localparam bit PSC = 1'b1;
`else
  localparam bit PSC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        irqout;
  logic        rst2, rd2, wr2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        irq2;

  always #5 clk = ~clk;

  mmio_timer_bank dut (
    .clk(clk), .reset(rst), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irqout(irqout)
  );

  mmio_timer_bank #(.N_TIMERS(2), .TW(16), .BASE(BASE)) dut2 (
    .clk(clk), .reset(rst2), .rd(rd2), .wr(wr2), .addr(addr2),
    .wdata(wdata2), .rdata(rdata2), .irqout(irq2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: four channels, 32-bit counters.
  logic [31:0] m_th [4];
  logic [31:0] m_tl [4];
  logic [2:0]  m_tcon [4];
  logic [15:0] m_pv [4];
  logic [15:0] m_pc [4];
  logic [3:0]  m_pend;

  function automatic logic [31:0] m_read(input logic r, input logic [31:0] a);
    logic [31:0] off;
    int ch;
    off = a - BASE;
    if (!r) return 32'h0;
    if (off == 32'h80) return {28'h0, m_pend};
    if (off >= 64 || (off % 4) != 0) return 32'h0;
    ch = int'(off / 16);
    case ((off % 16) / 4)
      0: return m_th[ch];
      1: return m_tl[ch];
      2: return {29'h0, m_tcon[ch]};
      default: return {16'h0, m_pv[ch]};
    endcase
  endfunction

  function automatic logic m_irq();
    logic any = 1'b0;
    for (int i = 0; i < 4; i++) any = any | (m_pend[i] & m_tcon[i][1]);
    return any;
  endfunction

  task automatic m_step();
    logic [3:0]  tick, setm, clrm;
    logic [31:0] off;
    int ch;
    if (rst) begin
      m_pend = 4'h0;
      for (int i = 0; i < 4; i++) begin
        m_th[i] = 0; m_tl[i] = 0; m_tcon[i] = 0; m_pv[i] = 0; m_pc[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 4; i++) tick[i] = m_tcon[i][0] && (!PSC || m_pc[i] == m_pv[i]);
    clrm = (wr && addr == IRQA) ? wdata[3:0] : 4'h0;
    setm = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (m_tcon[i][0]) m_pc[i] = tick[i] ? 16'd0 : m_pc[i] + 16'd1;
      if (tick[i]) begin
        if (m_tl[i] == 32'hFFFFFFFF) begin
          m_tl[i] = m_th[i];
          setm[i] = 1'b1;
          if (m_tcon[i][2]) m_tcon[i][0] = 1'b0;
        end else begin
          m_tl[i] = m_tl[i] + 1;
        end
      end
    end
    m_pend = (m_pend & ~clrm) | setm;
    off = addr - BASE;
    if (wr && off < 64 && (off % 4) == 0) begin
      ch = int'(off / 16);
      case ((off % 16) / 4)
        0: m_th[ch] = wdata;
        1: m_tl[ch] = wdata;
        2: begin m_tcon[ch] = wdata[2:0]; m_pc[ch] = 0; end
        default: if (PSC) begin m_pv[ch] = wdata[15:0]; m_pc[ch] = 0; end
      endcase
    end
  endtask

  logic [31:0] s_rdata, s2_rdata;
  logic        s_irq, s2_irq;

  task automatic cycle(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr = w; rd = r; addr = a; wdata = d;
    @(negedge clk);
    s_rdata = rdata; s_irq = irqout;
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic cycle2(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr2 = w; rd2 = r; addr2 = a; wdata2 = d;
    @(negedge clk);
    s2_rdata = rdata2; s2_irq = irq2;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ra(input int ch, input int r);
    return BASE + 32'(16 * ch + 4 * r);
  endfunction

  task automatic wreg(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic rchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    cycle(1'b0, 1'b1, a, 32'h0);
    chk(name, s_rdata, exp);
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e_rd;
    logic        e_irq;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, ra(0, 0), 32'h0, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, IRQA, 32'h0, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, ra(1, 0), 32'h12345678, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, ra(1, 0), 32'h0, 32'h12345678, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, ra(1, 2), 32'hFFFFFFFE, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, ra(1, 2), 32'h0, 32'h6, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, ra(3, 1), 32'hCAFEBABE, 32'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, ra(3, 1), 32'h0, 32'hCAFEBABE, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, BASE + 32'h40, 32'h0, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, ra(1, 0), 32'h0, 32'h0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, ra(2, 3), 32'hABCD1234, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, ra(2, 3), 32'h0, PSC ? 32'h1234 : 32'h0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, BASE + 32'h84, 32'h0, 32'h0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, ra(1, 0) + 32'h1, 32'h0, 32'h0, 1'b0};

    rst = 1'b1; rst2 = 1'b1;
    rd2 = 1'b0; wr2 = 1'b0; addr2 = 32'h0; wdata2 = 32'h0;
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    chk("reset_irqout", 32'(s_irq), 32'h0);

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_rdata", i), s_rdata, tbl[i].e_rd);
      chk($sformatf("tbl%0d_irq", i), 32'(s_irq), 32'(tbl[i].e_irq));
    end

    // Auto-reload overflow on ch0.
    wreg(ra(0, 0), 32'hFFFFFFFE);
    wreg(ra(0, 1), 32'hFFFFFFFE);
    wreg(ra(0, 2), 32'h3);
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    rchk("reload_tl", ra(0, 1), 32'hFFFFFFFE);
    chk("reload_irqout", 32'(s_irq), 32'h1);
    rchk("reload_status", IRQA, 32'h1);
    rchk("reload_again_tl", ra(0, 1), 32'hFFFFFFFE);
    wreg(ra(0, 2), 32'h0);
    wreg(IRQA, 32'hF);

    // One-shot overflow on ch2.
    wreg(ra(2, 0), 32'h55);
    wreg(ra(2, 1), 32'hFFFFFFFF);
    wreg(ra(2, 2), 32'h7);
    rchk("os_pre_tl", ra(2, 1), 32'hFFFFFFFF);
    rchk("os_tl", ra(2, 1), 32'h55);
    rchk("os_tcon", ra(2, 2), 32'h6);
    rchk("os_status", IRQA, 32'h4);
    rchk("os_stopped_tl", ra(2, 1), 32'h55);
    wreg(IRQA, 32'h4);
    wreg(ra(2, 2), 32'h0);

    // W1C on ch0/ch1, then W1C racing a fresh overflow on ch1.
    wreg(ra(0, 1), 32'hFFFFFFFF);
    wreg(ra(1, 1), 32'hFFFFFFFF);
    wreg(ra(0, 2), 32'h5);
    wreg(ra(1, 2), 32'h5);
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    rchk("w1c_both", IRQA, 32'h3);
    chk("w1c_irq_masked", 32'(s_irq), 32'h0);
    wreg(IRQA, 32'h1);
    rchk("w1c_bit0", IRQA, 32'h2);
    wreg(ra(1, 1), 32'hFFFFFFFF);
    wreg(ra(1, 2), 32'h5);
    wreg(IRQA, 32'h2);
    rchk("w1c_race", IRQA, 32'h2);
    wreg(IRQA, 32'h2);
    rchk("w1c_clear", IRQA, 32'h0);

    // Pending with IE=0, then enabling IE.
    wreg(ra(3, 1), 32'hFFFFFFFF);
    wreg(ra(3, 2), 32'h5);
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    rchk("ie0_status", IRQA, 32'h8);
    chk("ie0_irqout", 32'(s_irq), 32'h0);
    wreg(ra(3, 2), 32'h2);
    rchk("ie1_tcon", ra(3, 2), 32'h2);
    chk("ie1_irqout", 32'(s_irq), 32'h1);
    wreg(IRQA, 32'h8);
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    chk("ie1_cleared", 32'(s_irq), 32'h0);
    wreg(ra(3, 2), 32'h0);

    // Prescale (or every-cycle counting when the prescaler is absent).
    wreg(ra(1, 3), 32'h3);
    wreg(ra(1, 1), 32'h0);
    wreg(ra(1, 2), 32'h1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    rchk("psc_tl4", ra(1, 1), PSC ? 32'h1 : 32'h4);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    rchk("psc_tl8", ra(1, 1), PSC ? 32'h2 : 32'h8);
    rchk("psc_reg", ra(1, 3), PSC ? 32'h3 : 32'h0);
    wreg(ra(1, 2), 32'h0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      logic        w, r;
      logic [31:0] a, d, e_rd;
      logic        e_irq;
      int sel, ch, rg;
      sel = $urandom_range(0, 9);
      ch = $urandom_range(0, 3);
      rg = $urandom_range(0, 3);
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (sel < 8) begin
        a = ra(ch, rg);
        if (rg == 1 && $urandom_range(0, 3) != 0) d = 32'hFFFFFFF0 | (d & 32'hF);
        if (rg == 3) d = (d & 32'hFFFF0000) | 32'($urandom_range(0, 3));
      end else if (sel == 8) begin
        a = IRQA;
      end else begin
        a = ($urandom_range(0, 1) == 1) ? $urandom : BASE + 32'h40 + 32'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 299) == 0);
      e_rd = m_read(r, a);
      e_irq = m_irq();
      cycle(w, r, a, d);
      rst = 1'b0;
      chk("rnd_rdata", s_rdata, e_rd);
      chk("rnd_irqout", 32'(s_irq), 32'(e_irq));
    end

    // Narrow two-channel instance: width truncation, overflow, reset mid-count.
    rst2 = 1'b0;
    cycle2(1'b1, 1'b0, BASE + 32'h0, 32'h1234);
    cycle2(1'b1, 1'b0, BASE + 32'h4, 32'h12345678);
    cycle2(1'b0, 1'b1, BASE + 32'h4, 32'h0);
    chk("n_tl_trunc", s2_rdata, 32'h5678);
    cycle2(1'b1, 1'b0, BASE + 32'h4, 32'hFFFE);
    cycle2(1'b1, 1'b0, BASE + 32'h8, 32'h3);
    cycle2(1'b0, 1'b0, 32'h0, 32'h0);
    cycle2(1'b0, 1'b0, 32'h0, 32'h0);
    cycle2(1'b0, 1'b1, BASE + 32'h4, 32'h0);
    chk("n_reload_tl", s2_rdata, 32'h1234);
    chk("n_irqout", 32'(s2_irq), 32'h1);
    rst2 = 1'b1;
    cycle2(1'b1, 1'b0, BASE + 32'h4, 32'h7777);
    cycle2(1'b0, 1'b1, BASE + 32'h4, 32'h0);
    chk("n_rst_read_tl", s2_rdata, 32'h0);
    rst2 = 1'b0;
    cycle2(1'b0, 1'b1, BASE + 32'h0, 32'h0);
    chk("n_rst_th", s2_rdata, 32'h0);
    chk("n_rst_irqout", 32'(s2_irq), 32'h0);
    cycle2(1'b0, 1'b1, BASE + 32'h8, 32'h0);
    chk("n_rst_tcon", s2_rdata, 32'h0);
    cycle2(1'b0, 1'b1, BASE + 32'h80, 32'h0);
    chk("n_rst_status", s2_rdata, 32'h0);
    cycle2(1'b0, 1'b1, BASE + 32'h4, 32'h0);
    chk("n_rst_tl_idle", s2_rdata, 32'h0);
    cycle2(1'b0, 1'b1, BASE + 32'h20, 32'h0);
    chk("n_unmapped_20", s2_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
